// File: rtl/vga_panel_pkg.sv
// Shared constants and types for the VGA register debug panel.
package vga_panel_pkg;

   localparam logic [2:0] COL_SET_CHG = 3'b110;
   localparam logic [2:0] COL_SET     = 3'b100;
   localparam logic [2:0] COL_CLR_CHG = 3'b001;
   localparam logic [2:0] COL_CLR     = 3'b000;

   localparam int SQ_SIZE  = 5;
   localparam int SQ_PITCH = 10;
   localparam int ROW_H    = 6;
   localparam int MAX_REGS = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      COMMIT  = 2'd2
   } cap_state_e;

   function automatic logic [2:0] bit_colour(input logic set, input logic chg);
      case ({set, chg})
         2'b11:   return COL_SET_CHG;
         2'b10:   return COL_SET;
         2'b01:   return COL_CLR_CHG;
         default: return COL_CLR;
      endcase
   endfunction

endpackage

// File: rtl/vga_register_panel_if.sv
// Bundle of CPU register-read and VGA pixel signals around the panel.
interface vga_register_panel_if;
   logic [7:0]  reg_data;
   logic [2:0]  reg_sel;
   logic        freeze;
   logic [10:0] vga_h;
   logic [10:0] vga_v;
   logic [2:0]  bg;
   logic [2:0]  pixel_out;
   logic        display_on;
   logic        busy;

   modport master (
      output reg_data, freeze, vga_h, vga_v, bg,
      input  reg_sel, pixel_out, display_on, busy
   );

   modport slave (
      input  reg_data, freeze, vga_h, vga_v, bg,
      output reg_sel, pixel_out, display_on, busy
   );
endinterface

// File: rtl/vga_panel_capture.sv
// Per-frame register snapshot: walks reg_sel, stages values, then commits
// shadow/changed together so the display never sees a partial snapshot.
module vga_panel_capture
   import vga_panel_pkg::*;
#(
   parameter int N_REGS    = 8,
   parameter int CAPTURE_V = 481
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] vga_h,
   input  logic [10:0] vga_v,
   input  logic        freeze,
   input  logic [7:0]  reg_data,
   output logic [2:0]  reg_sel,
   output logic        busy,
   output logic [63:0] shadow_flat,
   output logic [63:0] changed_flat
);

   localparam logic [10:0] CAP_V  = 11'(CAPTURE_V);
   localparam logic [3:0]  K_LAST = 4'(N_REGS);

   cap_state_e state_q, state_d;
   logic [3:0] k_q, k_d, k_m1;
   logic [7:0] staging_q [MAX_REGS];
   logic [7:0] staging_d [MAX_REGS];
   logic [7:0] shadow_q  [MAX_REGS];
   logic [7:0] shadow_d  [MAX_REGS];
   logic [7:0] changed_q [MAX_REGS];
   logic [7:0] changed_d [MAX_REGS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         for (int i = 0; i < MAX_REGS; i++) begin
            staging_q[i] <= '0;
            shadow_q[i]  <= '0;
            changed_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         staging_q <= staging_d;
         shadow_q  <= shadow_d;
         changed_q <= changed_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      staging_d = staging_q;
      shadow_d  = shadow_q;
      changed_d = changed_q;
      reg_sel   = '0;
      k_m1      = k_q - 4'd1;
      case (state_q)
         IDLE: begin
            if (vga_v == CAP_V && vga_h == 11'd0 && !freeze) begin
               state_d = CAPTURE;
               k_d     = '0;
            end
         end
         CAPTURE: begin
            if (k_q < K_LAST) reg_sel = k_q[2:0];
            // reg_data lags reg_sel by a cycle, so step k lands register k-1
            if (k_q != 4'd0) staging_d[k_m1[2:0]] = reg_data;
            if (k_q == K_LAST) state_d = COMMIT;
            else               k_d     = k_q + 4'd1;
         end
         COMMIT: begin
            for (int i = 0; i < MAX_REGS; i++) begin
               changed_d[i] = staging_q[i] ^ shadow_q[i];
               shadow_d[i]  = staging_q[i];
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      for (int i = 0; i < MAX_REGS; i++) begin
         shadow_flat[8*i +: 8]  = shadow_q[i];
         changed_flat[8*i +: 8] = changed_q[i];
      end
   end

endmodule

// File: rtl/vga_register_panel.sv
// VGA debug overlay showing up to eight CPU registers as rows of bit squares,
// highlighting bits that changed at the last snapshot.
module vga_register_panel
   import vga_panel_pkg::*;
#(
   parameter int START_H   = 10,
   parameter int START_V   = 380,
   parameter int ROW_PITCH = 8,
   parameter int N_REGS    = 8,
   parameter int CAPTURE_V = 481
) (
   input  logic                 clk,
   input  logic                 reset,
   vga_register_panel_if.slave  bus
);

   localparam logic [10:0] SH   = 11'(START_H);
   localparam logic [10:0] SV   = 11'(START_V);
   localparam logic [10:0] H_LO = 11'(START_H - SQ_SIZE);
   localparam logic [10:0] H_HI = 11'(START_H + 8 * SQ_PITCH);

   logic [63:0] shadow_flat, changed_flat;
   logic [10:0] dv, dh, line;
   logic [2:0]  row, bj;
   logic        in_row, in_span, in_sq;
   logic [2:0]  pixel_q, pixel_d;
   logic        on_q, on_d;

   vga_panel_capture #(
      .N_REGS    (N_REGS),
      .CAPTURE_V (CAPTURE_V)
   ) u_capture (
      .clk          (clk),
      .reset        (reset),
      .vga_h        (bus.vga_h),
      .vga_v        (bus.vga_v),
      .freeze       (bus.freeze),
      .reg_data     (bus.reg_data),
      .reg_sel      (bus.reg_sel),
      .busy         (bus.busy),
      .shadow_flat  (shadow_flat),
      .changed_flat (changed_flat)
   );

   // Row and bit lookup by comparison chains; rows never overlap as pitch >= 6
   always_comb begin
      dv     = bus.vga_v - SV;
      dh     = bus.vga_h - SH;
      in_row = 1'b0;
      row    = '0;
      line   = '0;
      in_sq  = 1'b0;
      bj     = '0;
      if (bus.vga_v >= SV) begin
         for (int i = 0; i < N_REGS; i++) begin
            if (dv >= 11'(i * ROW_PITCH) && dv < 11'(i * ROW_PITCH + ROW_H)) begin
               in_row = 1'b1;
               row    = 3'(i);
               line   = dv - 11'(i * ROW_PITCH);
            end
         end
      end
      in_span = (bus.vga_h >= H_LO) && (bus.vga_h < H_HI);
      if (bus.vga_h >= SH) begin
         for (int c = 0; c < 8; c++) begin
            if (dh >= 11'(c * SQ_PITCH) && dh < 11'(c * SQ_PITCH + SQ_SIZE)) begin
               in_sq = 1'b1;
               bj    = 3'(7 - c);
            end
         end
      end
      on_d    = in_row && in_span;
      pixel_d = bus.bg;
      if (on_d && in_sq && line < 11'(SQ_SIZE))
         pixel_d = bit_colour(shadow_flat[{row, bj}], changed_flat[{row, bj}]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixel_q <= '0;
         on_q    <= 1'b0;
      end else begin
         pixel_q <= pixel_d;
         on_q    <= on_d;
      end
   end

   assign bus.pixel_out  = pixel_q;
   assign bus.display_on = on_q;

endmodule

// File: tb/tb_vga_register_panel.sv
// Bench for vga_register_panel: default instance and an N_REGS=3/ROW_PITCH=10
// instance share stimulus; each is checked against its own snapshot model.
module tb_vga_register_panel;

   localparam int SH   = 10;
   localparam int SV   = 380;
   localparam int CAPV = 481;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vga_register_panel_if a_if ();
   vga_register_panel_if b_if ();

   vga_register_panel dut_a (.clk(clk), .reset(reset), .bus(a_if));
   vga_register_panel #(.N_REGS(3), .ROW_PITCH(10)) dut_b (.clk(clk), .reset(reset), .bus(b_if));

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] cpu_regs [8];
   logic [7:0] sh_m [2][8];
   logic [7:0] ch_m [2][8];
   int n_m [2] = '{8, 3};
   int p_m [2] = '{8, 10};
   logic [2:0] a_prev = '0;
   logic [2:0] b_prev = '0;

   // CPU register mux with one cycle of read latency
   always @(negedge clk) begin
      a_if.reg_data = cpu_regs[a_prev];
      a_prev        = a_if.reg_sel;
      b_if.reg_data = cpu_regs[b_prev];
      b_prev        = b_if.reg_sel;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int h, input int v, input logic [2:0] bgc, input logic frz);
      a_if.vga_h  = 11'(h);  b_if.vga_h  = 11'(h);
      a_if.vga_v  = 11'(v);  b_if.vga_v  = 11'(v);
      a_if.bg     = bgc;     b_if.bg     = bgc;
      a_if.freeze = frz;     b_if.freeze = frz;
   endtask

   task automatic model_clear();
      for (int x = 0; x < 2; x++)
         for (int i = 0; i < 8; i++) begin
            sh_m[x][i] = '0;
            ch_m[x][i] = '0;
         end
   endtask

   // Returns {display_on, pixel_out} expected for instance x at (h, v)
   function automatic logic [3:0] exp_px(input int x, input int h, input int v, input logic [2:0] bgc);
      int row, line, off, bj;
      logic s, c;
      if (v < SV) return {1'b0, bgc};
      row  = (v - SV) / p_m[x];
      line = (v - SV) % p_m[x];
      if (row >= n_m[x] || line >= 6 || h < SH - 5 || h >= SH + 80) return {1'b0, bgc};
      if (line == 5 || h < SH) return {1'b1, bgc};
      off = h - SH;
      if (off % 10 >= 5) return {1'b1, bgc};
      bj = 7 - off / 10;
      s  = sh_m[x][row][bj];
      c  = ch_m[x][row][bj];
      if (s && c)  return {1'b1, 3'b110};
      if (s)       return {1'b1, 3'b100};
      if (c)       return {1'b1, 3'b001};
      return {1'b1, 3'b000};
   endfunction

   task automatic probe(input int h, input int v);
      logic [2:0] bgc;
      bgc = 3'($urandom);
      set_in(h, v, bgc, 1'b0);
      tick();
      check_eq($sformatf("pix_a(%0d,%0d)", h, v), {28'd0, a_if.display_on, a_if.pixel_out}, {28'd0, exp_px(0, h, v, bgc)});
      check_eq($sformatf("pix_b(%0d,%0d)", h, v), {28'd0, b_if.display_on, b_if.pixel_out}, {28'd0, exp_px(1, h, v, bgc)});
   endtask

   task automatic probe_rows();
      for (int r = 0; r < 8; r++)
         for (int j = 0; j < 8; j++)
            probe(SH + (7 - j) * 10 + 2, SV + r * 8 + 2);
   endtask

   task automatic probe_rand(input int n);
      repeat (n) probe($urandom_range(0, 100), $urandom_range(374, 420));
   endtask

   task automatic do_frame(input logic frz, input logic mid_frz);
      set_in(0, CAPV, 3'd0, frz);
      tick();
      a_if.vga_h = 11'd1;
      b_if.vga_h = 11'd1;
      for (int c = 1; c <= 12; c++) begin
         if (mid_frz && c == 3) begin
            a_if.freeze = 1'b1;
            b_if.freeze = 1'b1;
         end
         check_eq($sformatf("busy_a c%0d", c), {31'd0, a_if.busy}, {31'd0, !frz && c <= n_m[0] + 2});
         check_eq($sformatf("busy_b c%0d", c), {31'd0, b_if.busy}, {31'd0, !frz && c <= n_m[1] + 2});
         check_eq($sformatf("sel_a c%0d", c), {29'd0, a_if.reg_sel}, (!frz && c - 1 < n_m[0]) ? c - 1 : 0);
         check_eq($sformatf("sel_b c%0d", c), {29'd0, b_if.reg_sel}, (!frz && c - 1 < n_m[1]) ? c - 1 : 0);
         tick();
      end
      if (!frz)
         for (int x = 0; x < 2; x++)
            for (int i = 0; i < n_m[x]; i++) begin
               ch_m[x][i] = cpu_regs[i] ^ sh_m[x][i];
               sh_m[x][i] = cpu_regs[i];
            end
      set_in(0, 0, 3'd0, 1'b0);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_pix_a"},  {29'd0, a_if.pixel_out}, 0);
      check_eq({tag, "_on_a"},   {31'd0, a_if.display_on}, 0);
      check_eq({tag, "_busy_a"}, {31'd0, a_if.busy}, 0);
      check_eq({tag, "_sel_a"},  {29'd0, a_if.reg_sel}, 0);
      check_eq({tag, "_pix_b"},  {29'd0, b_if.pixel_out}, 0);
      check_eq({tag, "_on_b"},   {31'd0, b_if.display_on}, 0);
      check_eq({tag, "_busy_b"}, {31'd0, b_if.busy}, 0);
      check_eq({tag, "_sel_b"},  {29'd0, b_if.reg_sel}, 0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) cpu_regs[i] = '0;
      model_clear();
      reset = 1'b1;
      set_in(0, 0, 3'd0, 1'b0);
      tick();
      tick();
      check_reset_vals("rst");
      reset = 1'b0;
      tick();

      // Frame 1: registers 0..7, all changed from zero
      for (int i = 0; i < 8; i++) cpu_regs[i] = 8'(i);
      do_frame(1'b0, 1'b0);
      probe(SH + 70, SV + 24);
      probe(SH + 60, SV + 24);
      probe_rows();

      // Frame 2: same values, nothing changed
      do_frame(1'b0, 1'b0);
      probe_rows();
      probe(SH + 81, SV);
      probe(SH + 5, SV + 1);
      probe(SH - 3, SV + 1);
      probe_rand(40);

      // Register 0 goes 0xFF then 0x0F
      cpu_regs[0] = 8'hFF;
      do_frame(1'b0, 1'b0);
      cpu_regs[0] = 8'h0F;
      do_frame(1'b0, 1'b0);
      probe_rows();

      // Freeze at trigger holds the display; freeze mid-capture does not abort
      for (int i = 0; i < 8; i++) cpu_regs[i] = 8'($urandom);
      do_frame(1'b1, 1'b0);
      probe_rows();
      do_frame(1'b0, 1'b1);
      probe_rows();

      // Reset in the middle of a capture
      set_in(0, CAPV, 3'b111, 1'b0);
      tick();
      a_if.vga_h = 11'd1;
      b_if.vga_h = 11'd1;
      tick();
      tick();
      tick();
      reset = 1'b1;
      #1;
      check_reset_vals("midrst");
      model_clear();
      tick();
      reset = 1'b0;
      set_in(0, 0, 3'd0, 1'b0);
      tick();
      probe_rows();
      do_frame(1'b0, 1'b0);
      probe_rows();

      // Boundaries specific to the small instance
      probe(SH + 2, SV + 30);
      probe(SH + 2, SV + 5);
      probe(SH + 2, SV + 20);

      repeat (4) begin
         for (int i = 0; i < 8; i++) cpu_regs[i] = 8'($urandom);
         do_frame(1'b0, 1'b0);
         probe_rows();
         probe_rand(30);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_register_panel.md
# vga_register_panel

Multi-register debug overlay for the 8-bit computer's VGA output. Once per frame, during vertical blanking, it snapshots up to eight 8-bit CPU registers through a shared read-select port. During the visible frame it draws them as stacked rows of 5×5 bit squares. Bits that changed since the previous snapshot are highlighted. It sits between the CPU register read mux and the VGA pixel mux, and takes over the single-register display role for all registers at once.

## Interface
- START_H, 10, horizontal pixel of bit 7 square, row left edge
- START_V, 380, vertical pixel of row 0 top
- ROW_PITCH, 8, lines between row tops; must be ≥ 6
- N_REGS, 8, registers shown, 1..8
- CAPTURE_V, 481, line on which the snapshot starts; must be outside the visible area
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- reg_data  in  8  value of the register selected by reg_sel, valid one cycle after reg_sel changes
- reg_sel  out  3  register read select
- freeze  in  1  1 = skip snapshots; display holds its last values
- vga_h  in  11  current horizontal pixel count
- vga_v  in  11  current vertical pixel count
- bg  in  3  background pixel colour
- pixel_out  out  3  pixel colour at (vga_h, vga_v), registered
- display_on  out  1  1 = pixel_out overrides the background mux, registered
- busy  out  1  high while the capture FSM is not IDLE

## Operation
- FSM states:
  - IDLE: trigger = (vga_v == CAPTURE_V && vga_h == 0 && !freeze) → CAPTURE, k <= 0.
  - CAPTURE: k runs 0..N_REGS; reg_sel = k[2:0] while k < N_REGS. For k ≥ 1, staging[k-1] <= reg_data. At k == N_REGS → COMMIT.
  - COMMIT: changed[i] <= staging[i] ^ shadow[i], shadow[i] <= staging[i] for all i, in one cycle → IDLE.
- The display reads only shadow and changed, so a partial snapshot is never visible.
- freeze is sampled only at the trigger. Asserting it mid-capture does not abort the capture.
- A trigger condition arising while not IDLE is ignored.
- reg_sel holds 0 outside CAPTURE.
- Row i (0..N_REGS-1) region: vga_v in [START_V + i·ROW_PITCH, +6) and vga_h in [START_H-5, START_H+80).
  - Inside the region: on = 1.
  - Lit lines are the first 5 lines of the row; the 6th line outputs bg.
- Bit j square: h offset (vga_h - START_H) in [(7-j)·10, (7-j)·10+4]. Colour is taken from shadow[i][j] and changed[i][j]:
  - set and changed: 3'b110
  - set and unchanged: 3'b100
  - clear and changed: 3'b001
  - clear and unchanged: 3'b000
- Gaps between squares, and any pixel outside all rows: out = bg. Outside all rows, on = 0.
- Arithmetic: all position math in 11 bits, unsigned. Row index = (vga_v - START_V) / ROW_PITCH, computed by comparison chain, with no divider.

## Timing
- Reset values: pixel_out 0, display_on 0, reg_sel 0, busy 0, state IDLE, k 0. shadow, staging and changed are all 0.
- Reset mid-capture aborts the capture. shadow and changed become 0; the next frame's trigger captures normally.
- Pixel latency: pixel_out and display_on correspond to vga_h/vga_v presented 1 cycle earlier.
- Capture duration: trigger cycle T, then CAPTURE cycles T+1..T+1+N_REGS, then COMMIT at T+2+N_REGS. busy is high T+1..T+2+N_REGS.
- reg_sel = r during cycle T+1+r. The matching reg_data is sampled at the end of cycle T+2+r.
- The new shadow is visible at pixel_out from cycle T+4+N_REGS. It is stable for the whole next visible frame.
- changed persists until the next COMMIT. With freeze held, changed keeps its last value.

## Structure
- Shared package vga_panel_pkg:
  - colour constants COL_SET_CHG, COL_SET, COL_CLR_CHG, COL_CLR
  - capture state enum (IDLE, CAPTURE, COMMIT)
  - square size 5, square pitch 10, row height 6
- One sub-module, vga_panel_capture: holds the FSM, k, reg_sel, staging, shadow and changed, and exports shadow/changed as flat buses.
- The top level holds the row/bit decode and the output registers.

## Test plan
- Reset then frame 1: registers = {0x00..0x07}, trigger. Expect reg_sel 0..7 on T+1..T+8, busy for 10 cycles. Expect row 3, bit 0 square at (START_H+70, START_V+24) = 3'b110 and row 3, bit 1 square = 3'b110 (set and changed from 0).
- Frame 2 with the same values: all set bits 3'b100, clear bits 3'b000, gaps = bg, display_on = 0 at (START_H+81, START_V).
- Register 0 goes 0xFF → 0x0F: bits 7..4 of row 0 show 3'b001, bits 3..0 show 3'b100.
- freeze = 1 at trigger: busy stays 0, reg_sel stays 0, and the display is unchanged despite reg_data changes. freeze raised at T+3: the capture completes and commits.
- reset asserted at T+4: outputs return to reset values immediately. The next frame captures correctly and all rows show changed-from-0 colouring.
- N_REGS = 3, ROW_PITCH = 10: capture takes T+1..T+4 and commits at T+5. A pixel at row 3's position shows bg with display_on = 0. The 6th line of row 0 (START_V+5) shows bg with display_on = 1.
